reflet_float_div: RTL and testbench

//  Divides two floating point numbers (quotient = in1 / in2) for the Reflet FPU datapath.

---
 rtl/reflet_float_div_pkg.sv | 27 ++
 rtl/reflet_float_div_div.sv | 60 ++++++
 rtl/reflet_float_div.sv | 96 +++++++++
 tb/tb_reflet_float_div.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reflet_float_div_pkg.sv
// Shared float-format helpers and FSM encoding for the Reflet FPU divider.
package reflet_float_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - 1 - exponent_size(float_size);
    endfunction

    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

endpackage

// File: rtl/reflet_float_div_div.sv
// Iterative restoring divider for hidden-bit mantissas, one quotient bit per clock.
module reflet_float_div_div
    import reflet_float_div_pkg::*;
#(
    parameter int size = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size:0]   quotient,
    output logic            valid
);

    localparam int CW = $clog2(size + 1);

    logic            running;
    logic [CW-1:0]   step_q;
    logic [size+1:0] rem_q;
    logic [size+1:0] dvs_q;
    logic [size-1:0] q_q;
    logic            qbit;
    logic [size+1:0] rem_next;

    assign qbit     = (rem_q >= dvs_q);
    assign rem_next = qbit ? (rem_q - dvs_q) : rem_q;

    // The final bit is exposed combinationally so the caller can register the
    // complete quotient on the same edge as the last iteration.
    assign quotient = {q_q, qbit};
    assign valid    = running && (step_q == CW'(size));

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            step_q  <= '0;
        end else if (start) begin
            running <= 1'b1;
            step_q  <= '0;
        end else if (running) begin
            if (step_q == CW'(size)) begin
                running <= 1'b0;
            end
            step_q <= step_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_q <= {2'b00, a};
            dvs_q <= {2'b00, b};
            q_q   <= '0;
        end else if (running) begin
            rem_q <= rem_next << 1;
            q_q   <= {q_q[size-2:0], qbit};
        end
    end

endmodule

// File: rtl/reflet_float_div.sv
// Floating point divider: FSM, special cases, exponent/sign and normalisation around the mantissa divider.
module reflet_float_div
    import reflet_float_div_pkg::*;
#(
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic [float_size-1:0] div,
    output logic                  busy,
    output logic                  done
);

    localparam int M = mantissa_size(float_size);
    localparam int E = exponent_size(float_size);
    localparam logic [E-1:0] BIAS = E'(exponent_bias(float_size));

    div_state_t            state_q, state_d;
    logic [float_size-1:0] result_q;
    logic                  sign_q;
    logic [E-1:0]          exp_q;
    logic                  accept, in1_zero, in2_zero, zero_op, sign_in;
    logic [M+1:0]          dv_quotient;
    logic                  dv_valid;

    // Q holds Q[M+1].Q[M:0] in (0.5, 2); a missing integer bit costs one exponent step.
    function automatic logic [float_size-1:0] normalise(input logic sgn, input logic [E-1:0] e,
                                                        input logic [M+1:0] q);
        logic [E-1:0] e_low;
        e_low = e - E'(1);
        if (q[M+1]) return {sgn, e, q[M:1]};
        else        return {sgn, e_low, q[M-1:0]};
    endfunction

    function automatic logic [float_size-1:0] special_result(input logic sgn, input logic num_zero);
        if (num_zero) return {sgn, {(float_size-1){1'b0}}};
        else          return {sgn, {E{1'b1}}, {M{1'b0}}};
    endfunction

    assign accept   = (state_q == IDLE) && start && enable;
    assign in1_zero = (in1[float_size-2:0] == '0);
    assign in2_zero = (in2[float_size-2:0] == '0);
    assign zero_op  = in1_zero || in2_zero;
    assign sign_in  = in1[float_size-1] ^ in2[float_size-1];

    reflet_float_div_div #(.size(M + 1)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && !zero_op),
        .a        ({1'b1, in1[M-1:0]}),
        .b        ({1'b1, in2[M-1:0]}),
        .quotient (dv_quotient),
        .valid    (dv_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = zero_op ? DONE : CALC;
            CALC:    if (dv_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && zero_op) begin
                result_q <= special_result(sign_in, in1_zero);
            end else if (state_q == CALC && dv_valid) begin
                result_q <= normalise(sign_q, exp_q, dv_quotient);
            end
        end
    end

    // Exponent wraps modulo 2^E by design: no saturation, no denormals.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= sign_in;
            exp_q  <= in1[float_size-2:M] - in2[float_size-2:M] + BIAS;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign div  = enable ? result_q : '0;

endmodule

// File: tb/tb_reflet_float_div.sv
// Randomised self-checking bench for reflet_float_div (float32) against an arithmetic reference.
module tb_reflet_float_div;

    logic        clk = 1'b0;
    logic        reset, enable, start;
    logic [31:0] in1, in2, div;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    reflet_float_div #(.float_size(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .div    (div),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: value-level quotient floor((ma/mb) * 2^24) with real exponent arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic       s;
        longint     ma, mb, q;
        int         e;
        logic [7:0] e8;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0) return {s, 31'd0};
        if (b[30:0] == 31'd0) return {s, 8'hFF, 23'd0};
        ma = longint'(a[22:0]) + (longint'(1) << 23);
        mb = longint'(b[22:0]) + (longint'(1) << 23);
        q  = (ma << 24) / mb;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= (longint'(1) << 24)) begin
            e8 = 8'(e);
            return {s, e8, 23'(q >> 1)};
        end
        e8 = 8'(e - 1);
        return {s, e8, 23'(q)};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int lat);
        lat = first;
        while (!done && lat < first + 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_val);
        int lat;
        launch(a, b);
        wait_done(1, lat);
        chk({tag, "_lat"}, 32'(lat), ((a[30:0] == 0) || (b[30:0] == 0)) ? 32'd1 : 32'd26);
        chk({tag, "_val"}, div, exp_val);
    endtask

    initial begin
        int lat, busy_cnt;
        logic seen_done;
        logic [31:0] a, b;

        reset = 1'b1; enable = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_div", div, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // 6/2 with busy window and single-cycle done pulse
        launch(32'h40C00000, 32'h40000000);
        busy_cnt = 0;
        lat = 1;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk("six_lat", 32'(lat), 32'd26);
        chk("six_busy_cycles", 32'(busy_cnt), 32'd25);
        chk("six_busy_at_done", 32'(busy), 32'd0);
        chk("six_val", div, 32'h40400000);
        @(negedge clk);
        chk("six_done_pulse", 32'(done), 32'd0);

        run_case("third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        run_case("neg", 32'hBFC00000, 32'h3F000000, 32'hC0400000);
        run_case("zero_num", 32'h00000000, 32'h40000000, 32'h00000000);
        run_case("zero_den", 32'h3F800000, 32'h80000000, 32'hFF800000);
        run_case("zero_zero", 32'h80000000, 32'h00000000, 32'h80000000);
        run_case("exp_wrap", 32'h7F000000, 32'h00800000, ref_div(32'h7F000000, 32'h00800000));

        // start while busy is ignored
        launch(32'h40C00000, 32'h40000000);
        repeat (3) @(negedge clk);
        in1 = 32'h3F800000; in2 = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat);
        chk("ignore_lat", 32'(lat), 32'd26);
        chk("ignore_val", div, 32'h40400000);

        // reset mid-operation aborts without a done pulse
        launch(32'h3F800000, 32'h40400000);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_div", div, 32'd0);
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        run_case("after_abort", 32'hBFC00000, 32'h3F000000, 32'hC0400000);

        // enable low blocks start
        enable = 1'b0;
        launch(32'h40C00000, 32'h40000000);
        repeat (2) @(negedge clk);
        chk("en_low_busy", 32'(busy), 32'd0);
        chk("en_low_div", div, 32'd0);

        // in-flight division completes while enable is low; result shows once enable returns
        enable = 1'b1;
        launch(32'h40C00000, 32'h40000000);
        enable = 1'b0;
        wait_done(1, lat);
        chk("en_gate_lat", 32'(lat), 32'd26);
        chk("en_gate_div", div, 32'd0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        #1;
        chk("en_held_div", div, 32'h40400000);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 9) == 0) a[30:0] = '0;
            if ($urandom_range(0, 9) == 0) b[30:0] = '0;
            run_case("rand", a, b, ref_div(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
